rr_grant_data_mux: RTL and testbench
====================================

Name: rr_grant_data_mux

Overview:
- Downstream consumer of the 4-requester round-robin arbiter's one-hot GNT.
- Drives the arbiter's REQ from per-master valid lines.
- Steers the granted master's data beat into a 2-entry output FIFO and presents it on a single valid/ready output port, tagged with its source index.
- Also detects illegal (multi-hot) grants and keeps per-master accepted-beat counters.

Parameters:
- DATA_W, 32, width of each master's data beat
- CNT_W, 16, width of each per-master accepted-beat counter (wraps)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  4  per-master beat valid; bit i belongs to master i
- in_data  input  4*DATA_W  master i data on bits [i*DATA_W +: DATA_W]
- in_ready  output  4  per-master beat accepted this cycle when in_valid[i] & in_ready[i]
- req  output  4  request vector to arbiter REQ; req = in_valid (combinational)
- gnt  input  4  grant vector from arbiter GNT
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts head when out_valid & out_ready
- out_data  output  DATA_W  FIFO head data
- out_src  output  2  index of master that produced head beat
- gnt_err  output  1  sticky: illegal grant observed
- cnt_sel  input  2  selects counter shown on cnt_val
- cnt_val  output  CNT_W  accepted-beat count of master cnt_sel

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (reset sampled on rising clk).
- Reset values:
  - FIFO count = 0, out_valid = 0, out_data = 0, out_src = 0.
  - gnt_err = 0, all four counters = 0.
  - in_ready = 0 while reset high.
  - Reset mid-transfer discards buffered beats; no beat is accepted in the reset cycle.
- Grant decode:
  - gnt_legal = gnt is zero or exactly one-hot.
  - gidx = index of the set bit.
  - Multi-hot gnt sets gnt_err on the next edge; gnt_err stays 1 until reset.
  - While gnt is illegal, in_ready = 0.
- Ready rule:
  - in_ready[i] = gnt[i] & gnt_legal & (fifo_count < 2).
  - in_ready does not depend on out_ready (no comb path out_ready -> in_ready).
  - Consequence: with FIFO full, no push occurs even in a pop cycle.
- Push: when in_valid[gidx] & in_ready[gidx], write {gidx, in_data slice gidx} to FIFO tail and increment counter[gidx] (mod 2^CNT_W).
- Pop: when out_valid & out_ready, advance head.
- Latency: a beat accepted at edge N is visible on out_* after edge N (registered), i.e. 1 cycle min.
- Simultaneous push and pop at count 1: count stays 1, new beat becomes head, no bubble.
- Count 0, push only: count 1. Count 2, pop only: count 1.
- FIFO order is strict acceptance order. Head contents are stable while out_valid & ~out_ready.
- gnt = 0 (arbiter idle): no push; the FIFO still drains.
- Master protocol: in_valid[i] must hold with stable data until accepted. The grant may move away before acceptance; the beat then waits for the next grant to that master. No beat is duplicated or lost.
- gnt[i] set with in_valid[i] = 0 (master dropped): no push, no count change.
- cnt_val = counter[cnt_sel], combinational from registered counters.
- Counter wrap: at all ones, the next accept gives 0.

Test Plan:
- Reset: assert reset 2 cycles with in_valid = 4'b1111, gnt = 4'b0001 -> in_ready = 0, out_valid = 0, gnt_err = 0, cnt_val = 0 for all cnt_sel.
- Single beat: in_valid[2] = 1, data 0xA5A5_0002, gnt = 4'b0100, out_ready = 1 -> in_ready[2] = 1 that cycle; next cycle out_valid = 1, out_data = 0xA5A5_0002, out_src = 2; counter[2] = 1.
- Round robin: all masters valid, gnt cycles 0001/0010/0100/1000, out_ready = 1 -> out_src sequence 0,1,2,3 with one beat per cycle after 1-cycle latency; each counter = 1.
- Backpressure: out_ready = 0, gnt = 4'b0001, in_valid[0] held -> two beats accepted, then in_ready = 0 with count 2. Raise out_ready -> head pops, and the next beat is accepted the cycle after count drops.
- Illegal grant: gnt = 4'b0011 one cycle, all valid -> in_ready = 0, no push, gnt_err = 1 next cycle and stays 1 after gnt returns legal; cleared only by reset.
- Counter wrap with CNT_W = 4: 17 beats from master 3 -> cnt_sel = 3 shows 1.

Source files
------------

// File: rtl/rr_grant_data_mux.sv
// Grant-steered data mux: routes the one-hot-granted master beat into a
// 2-entry FIFO tagged with its source, flags multi-hot grants, counts accepts.

module rr_beat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)      r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module rr_grant_data_mux #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic [3:0]          req,
  input  logic [3:0]          gnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_src,
  output logic                gnt_err,
  input  logic [1:0]          cnt_sel,
  output logic [CNT_W-1:0]    cnt_val
);
  typedef struct packed {
    logic [1:0]        src;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              w_legal;
  logic              w_room;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_gidx;
  logic [DATA_W-1:0] w_gdata;
  logic [CNT_W-1:0]  w_cnt [4];

  beat_t             r_mem [2];
  logic              r_wr;
  logic              r_rd;
  logic [1:0]        r_count;
  logic              r_err;

  assign req     = in_valid;
  // Zero or exactly one bit set; clearing the lowest set bit must leave nothing.
  assign w_legal = ((gnt & (gnt - 4'd1)) == 4'd0);
  assign w_room  = (r_count != 2'd2);
  assign in_ready = (reset || !w_legal || !w_room) ? 4'b0000 : gnt;

  always_comb begin
    w_gidx  = 2'd0;
    w_gdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        w_gidx  = 2'(i);
        w_gdata = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_push = |(in_valid & in_ready);
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= '{src: w_gidx, data: w_gdata};
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rd].data;
  assign out_src   = r_mem[r_rd].src;

  always_ff @(posedge clk) begin
    if (reset)         r_err <= 1'b0;
    else if (!w_legal) r_err <= 1'b1;
  end
  assign gnt_err = r_err;

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    rr_beat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (in_valid[g] & in_ready[g]),
      .o_cnt (w_cnt[g])
    );
  end

  assign cnt_val = w_cnt[cnt_sel];
endmodule

// File: tb/tb_rr_grant_data_mux.sv
// Randomized and directed checks of rr_grant_data_mux against a queue-based
// model of the acceptance/FIFO rules.

module tb_rr_grant_data_mux;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic [3:0]      req;
  logic [3:0]      gnt;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            gnt_err;
  logic [1:0]      cnt_sel;
  logic [CW-1:0]   cnt_val;

  int total = 0;
  int bad   = 0;

  beat_t       q[$];
  int unsigned m_cnt[4];
  bit          m_err;
  logic [3:0]  acc;

  rr_grant_data_mux #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req(req), .gnt(gnt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .gnt_err(gnt_err), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
  );

  always #5 clk = ~clk;

  // Ready = grant, unless in reset, grant multi-hot or two beats already held.
  function automatic logic [3:0] model_rdy();
    if (reset) return 4'b0000;
    if ($countones(gnt) > 1) return 4'b0000;
    if (q.size() >= 2) return 4'b0000;
    return gnt;
  endfunction

  task automatic tick();
    logic [3:0] rdy;
    bit pop;
    rdy = model_rdy();
    pop = (q.size() > 0) && out_ready;
    @(posedge clk);
    acc = 4'b0000;
    if (reset) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_err = 0;
    end else begin
      if ($countones(gnt) > 1) m_err = 1;
      acc = in_valid & rdy;
      if (pop) void'(q.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          q.push_back('{src: 2'(i), data: in_data[i*DW +: DW]});
          m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    in_valid = 4'b0000; gnt = 4'b0000; out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    total++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL drain: out_valid=%b model_depth=%0d want empty", out_valid, q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'b1111; gnt = 4'b0001; out_ready = 1'b0;
    in_data = {4{32'hDEAD_BEEF}}; cnt_sel = 2'd0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (in_ready !== 4'b0000) begin
        bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0 || gnt_err !== 1'b0 || out_data !== '0 || out_src !== 2'd0) begin
      bad++; $display("FAIL reset_outputs: vld=%b err=%b data=%h src=%0d want 0", out_valid, gnt_err, out_data, out_src);
    end
    reset = 1'b0; in_valid = 4'b0000; gnt = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s); #1;
      total++;
      if (cnt_val !== '0) begin
        bad++; $display("FAIL reset_cnt%0d: got %0d want 0", s, cnt_val);
      end
    end
  endtask

  task automatic test_single();
    in_valid = 4'b0100; in_data[2*DW +: DW] = 32'hA5A5_0002; gnt = 4'b0100; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready: got %b want 0100", in_ready);
    end
    tick();
    in_valid = 4'b0000; gnt = 4'b0000; cnt_sel = 2'd2;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0002 || out_src !== 2'd2) begin
      bad++; $display("FAIL single_out: vld=%b data=%h src=%0d want 1 a5a50002 2", out_valid, out_data, out_src);
    end
    total++;
    if (cnt_val !== 4'd1) begin
      bad++; $display("FAIL single_cnt: got %0d want 1", cnt_val);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
    for (int c = 0; c < 5; c++) begin
      gnt = (c < 4) ? seq[c] : 4'b0000;
      if (c == 4) in_valid = 4'b0000;
      #1;
      if (c > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_src !== 2'(c - 1) || out_data !== 32'h1000_0000 + 32'(c - 1)) begin
          bad++; $display("FAIL rr_beat%0d: vld=%b src=%0d data=%h want src %0d", c - 1, out_valid, out_src, out_data, c - 1);
        end
      end
      tick();
    end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s); #1;
      total++;
      if (cnt_val !== CW'(m_cnt[s])) begin
        bad++; $display("FAIL rr_cnt%0d: got %0d want %0d", s, cnt_val, m_cnt[s]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] want [6];
    drain();
    want[0] = 4'b0001; want[1] = 4'b0001; want[2] = 4'b0000;
    want[3] = 4'b0000; want[4] = 4'b0000; want[5] = 4'b0001;
    in_valid = 4'b0001; gnt = 4'b0001; out_ready = 1'b0;
    in_data[DW-1:0] = 32'hB000_0000;
    for (int c = 0; c < 6; c++) begin
      out_ready = (c >= 4);
      #1;
      total++;
      if (in_ready !== want[c]) begin
        bad++; $display("FAIL bp_ready_c%0d: got %b want %b depth=%0d", c, in_ready, want[c], q.size());
      end
      if (q.size() > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== q[0].data || out_src !== q[0].src) begin
          bad++; $display("FAIL bp_head_c%0d: data=%h src=%0d want %h %0d", c, out_data, out_src, q[0].data, q[0].src);
        end
      end
      tick();
      if (acc[0]) in_data[DW-1:0] = in_data[DW-1:0] + 32'd1;
    end
    drain();
  endtask

  task automatic test_illegal();
    in_valid = 4'b1111; gnt = 4'b0011; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin
      bad++; $display("FAIL illegal_ready: got %b want 0000", in_ready);
    end
    tick();
    gnt = 4'b0000;
    #1;
    total++;
    if (gnt_err !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_err: err=%b vld=%b want 1 0", gnt_err, out_valid);
    end
    gnt = 4'b0001; tick(); gnt = 4'b0000; tick(); tick();
    total++;
    if (gnt_err !== 1'b1) begin
      bad++; $display("FAIL illegal_sticky: got %b want 1", gnt_err);
    end
    in_valid = 4'b0000; reset = 1'b1; tick(); reset = 1'b0;
    #1;
    total++;
    if (gnt_err !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_clear: err=%b vld=%b want 0 0", gnt_err, out_valid);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    in_valid = 4'b1000; gnt = 4'b1000; out_ready = 1'b1; cnt_sel = 2'd3;
    in_data[3*DW +: DW] = 32'h3300_0000;
    for (int k = 0; k < 60 && n < 17; k++) begin
      tick();
      if (acc[3]) begin
        n++;
        in_data[3*DW +: DW] = in_data[3*DW +: DW] + 32'd1;
      end
    end
    in_valid = 4'b0000; gnt = 4'b0000;
    #1;
    total++;
    if (n != 17 || cnt_val !== 4'd1) begin
      bad++; $display("FAIL wrap_cnt: accepted=%0d cnt=%0d want 17 1", n, cnt_val);
    end
    drain();
  endtask

  task automatic test_random();
    bit [3:0]  pend = 4'b0000;
    int unsigned r;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 2 == 1)) begin
          pend[i] = 1'b1;
          in_data[i*DW +: DW] = $urandom;
        end
      end
      in_valid = pend;
      r = $urandom % 10;
      if (r < 7)                        gnt = 4'b0001 << ($urandom % 4);
      else if (r < 9)                   gnt = 4'b0000;
      else if ($urandom % 16 == 0)      gnt = 4'($urandom);
      else                              gnt = 4'b0001 << ($urandom % 4);
      out_ready = ($urandom % 3 != 0);
      cnt_sel = 2'($urandom);
      #1;
      total++;
      if (in_ready !== model_rdy() || req !== in_valid) begin
        bad++; $display("FAIL rnd_ready_c%0d: rdy=%b req=%b want %b %b", c, in_ready, req, model_rdy(), in_valid);
      end
      total++;
      if (out_valid !== (q.size() > 0) || gnt_err !== m_err || cnt_val !== CW'(m_cnt[cnt_sel])) begin
        bad++; $display("FAIL rnd_state_c%0d: vld=%b err=%b cnt=%0d want %b %b %0d", c, out_valid, gnt_err, cnt_val, q.size() > 0, m_err, m_cnt[cnt_sel]);
      end
      if (q.size() > 0) begin
        total++;
        if (out_data !== q[0].data || out_src !== q[0].src) begin
          bad++; $display("FAIL rnd_head_c%0d: data=%h src=%0d want %h %0d", c, out_data, out_src, q[0].data, q[0].src);
        end
      end
      tick();
      pend = pend & ~acc;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
